frame_tick_scheduler: RTL and testbench

FRAME_TICK_SCHEDULER -- requirements
Module: frame_tick_scheduler

---
 rtl/frame_tick_scheduler_if.sv | 40 ++++
 rtl/frame_tick_scheduler.sv | 245 ++++++++++++++++++++++++
 tb/tb_frame_tick_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_tick_scheduler_if.sv
// ---------------------------------------------------------------------------
// frame_tick_scheduler_if
// Handshake bundle between the frame tick scheduler and the game datapath
// (snake-position logic, collision logic and board memory).
//
//   move_req   scheduler -> datapath : advance the snake one step
//   move_done  datapath -> scheduler : move finished
//   check_req  scheduler -> datapath : run the collision check
//   check_done datapath -> scheduler : collision check finished
//   collision  datapath -> scheduler : collision result, valid with check_done
//   commit     scheduler -> datapath : one-cycle pulse, board memory may update
//
// master : the scheduler side; slave : the datapath side.
// ---------------------------------------------------------------------------
interface frame_tick_scheduler_if;
  logic move_req;
  logic move_done;
  logic check_req;
  logic check_done;
  logic collision;
  logic commit;

  modport master (
    output move_req,
    output check_req,
    output commit,
    input  move_done,
    input  check_done,
    input  collision
  );

  modport slave (
    input  move_req,
    input  check_req,
    input  commit,
    output move_done,
    output check_done,
    output collision
  );
endinterface

// File: rtl/frame_tick_scheduler.sv
// ---------------------------------------------------------------------------
// frame_tick_scheduler
// Turns VGA vertical-blanking edges into game steps. Every eff_speed enabled
// frames a tick starts a MOVE -> CHECK -> COMMIT handshake sequence with the
// datapath; a collision ends the game in GAMEOVER until restart. Handshakes
// are guarded by a TIMEOUT watchdog, and running the step sequence outside
// vertical blanking (or dropping a tick because the sequence is still busy)
// is flagged in the sticky overrun bit.
//
// Ports
//   clk          system/pixel clock, rising edge
//   rst          asynchronous active-low reset
//   vblnk_in     vertical blanking from VGA timing
//   enable       game running; 0 freezes frame counting
//   speed_sel    frames per game step (0 behaves as 1)
//   restart      single-cycle pulse that leaves GAMEOVER
//   hs           handshake bundle (master side), see frame_tick_scheduler_if
//   game_over    high while in GAMEOVER
//   busy         high in MOVE, CHECK and COMMIT
//   overrun      sticky: sequence ran outside vblank, or a tick was dropped
//   timeout_err  sticky: a done handshake exceeded TIMEOUT cycles
// ---------------------------------------------------------------------------
module frame_tick_scheduler #(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vblnk_in,
  input  logic                     enable,
  input  logic [CNT_W-1:0]         speed_sel,
  input  logic                     restart,
  frame_tick_scheduler_if.master   hs,
  output logic                     game_over,
  output logic                     busy,
  output logic                     overrun,
  output logic                     timeout_err
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_MOVE     = 3'd1;
  localparam logic [2:0] ST_CHECK    = 3'd2;
  localparam logic [2:0] ST_COMMIT   = 3'd3;
  localparam logic [2:0] ST_GAMEOVER = 3'd4;

  localparam int              WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [2:0]        state_r;
  logic [2:0]        state_s;
  logic              vblnk_q_r;
  logic              armed_r;
  logic              tick_r;
  logic [CNT_W-1:0]  frame_cnt_r;
  logic [CNT_W-1:0]  eff_last_s;
  logic [WAIT_W-1:0] wait_r;
  logic              overrun_r;
  logic              timeout_err_r;
  logic              move_req_r;
  logic              check_req_r;
  logic              commit_r;
  logic              game_over_r;
  logic              busy_r;

  logic              frame_start_s;
  logic              busy_state_s;
  logic              count_en_s;
  logic              timeout_hit_s;
  logic              restart_go_s;

  // armed_r keeps a vblank that is already high when reset releases from
  // looking like a fresh rising edge: blanking must be seen low first.
  assign frame_start_s = vblnk_in & ~vblnk_q_r & armed_r;
  assign busy_state_s  = (state_r == ST_MOVE) || (state_r == ST_CHECK) ||
                         (state_r == ST_COMMIT);
  // Frames only count while idle; edges in busy states are dropped.
  assign count_en_s    = frame_start_s & enable & (state_r == ST_IDLE);

  // Last frame index of a step period: speed_sel-1, with 0 behaving as 1.
  always_comb begin
    eff_last_s = '0;
    if (speed_sel == '0) begin
      eff_last_s = '0;
    end else begin
      eff_last_s = speed_sel - CNT_W'(1);
    end
  end

  // Next-state logic of the step sequencer.
  always_comb begin
    state_s       = state_r;
    timeout_hit_s = 1'b0;
    restart_go_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tick_r) begin
          state_s = ST_MOVE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MOVE: begin
        if (hs.move_done) begin
          state_s = ST_CHECK;
        end else if (wait_r == WAIT_LAST) begin
          state_s       = ST_IDLE;
          timeout_hit_s = 1'b1;
        end else begin
          state_s = ST_MOVE;
        end
      end
      ST_CHECK: begin
        if (hs.check_done) begin
          if (hs.collision) begin
            state_s = ST_GAMEOVER;
          end else begin
            state_s = ST_COMMIT;
          end
        end else if (wait_r == WAIT_LAST) begin
          state_s       = ST_IDLE;
          timeout_hit_s = 1'b1;
        end else begin
          state_s = ST_CHECK;
        end
      end
      ST_COMMIT: begin
        state_s = ST_IDLE;
      end
      ST_GAMEOVER: begin
        if (restart) begin
          state_s      = ST_IDLE;
          restart_go_s = 1'b1;
        end else begin
          state_s = ST_GAMEOVER;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register and vblank edge detector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      vblnk_q_r <= 1'b0;
      armed_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      vblnk_q_r <= vblnk_in;
      armed_r   <= armed_r | ~vblnk_in;
    end
  end

  // Frame counter and tick generation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_r <= '0;
      tick_r      <= 1'b0;
    end else begin
      if (restart_go_s) begin
        frame_cnt_r <= '0;
        tick_r      <= 1'b0;
      end else if (count_en_s) begin
        if (frame_cnt_r >= eff_last_s) begin
          frame_cnt_r <= '0;
          tick_r      <= 1'b1;
        end else begin
          frame_cnt_r <= frame_cnt_r + CNT_W'(1);
          tick_r      <= 1'b0;
        end
      end else begin
        frame_cnt_r <= frame_cnt_r;
        tick_r      <= 1'b0;
      end
    end
  end

  // Handshake watchdog: restarts on every state change, counts while waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_r <= '0;
    end else begin
      if (state_s != state_r) begin
        wait_r <= '0;
      end else if ((state_r == ST_MOVE) || (state_r == ST_CHECK)) begin
        wait_r <= wait_r + WAIT_W'(1);
      end else begin
        wait_r <= '0;
      end
    end
  end

  // Sticky error flags, cleared only by restart from GAMEOVER or reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun_r     <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      if (restart_go_s) begin
        overrun_r <= 1'b0;
      end else if (busy_state_s && (frame_start_s || !vblnk_in)) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end

      if (restart_go_s) begin
        timeout_err_r <= 1'b0;
      end else if (timeout_hit_s) begin
        timeout_err_r <= 1'b1;
      end else begin
        timeout_err_r <= timeout_err_r;
      end
    end
  end

  // Outputs registered from the next state so they line up with state_r.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      move_req_r  <= 1'b0;
      check_req_r <= 1'b0;
      commit_r    <= 1'b0;
      game_over_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      move_req_r  <= (state_s == ST_MOVE);
      check_req_r <= (state_s == ST_CHECK);
      commit_r    <= (state_s == ST_COMMIT);
      game_over_r <= (state_s == ST_GAMEOVER);
      busy_r      <= (state_s == ST_MOVE) || (state_s == ST_CHECK) ||
                     (state_s == ST_COMMIT);
    end
  end

  assign hs.move_req  = move_req_r;
  assign hs.check_req = check_req_r;
  assign hs.commit    = commit_r;
  assign game_over    = game_over_r;
  assign busy         = busy_r;
  assign overrun      = overrun_r;
  assign timeout_err  = timeout_err_r;

endmodule

// File: tb/tb_frame_tick_scheduler.sv
// ---------------------------------------------------------------------------
// tb_frame_tick_scheduler
// Frame-level stimulus with a reference model of the frame counter; each
// predicted game step is pushed as a record (planned outcome, done delays,
// expected move_req cycle) into a queue. A separate monitor/responder pops a
// record whenever move_req appears, answers the handshakes and checks timing.
// ---------------------------------------------------------------------------
module tb_frame_tick_scheduler;
  localparam int TMO = 16;
  localparam int OUT_COMMIT = 0;
  localparam int OUT_OVER   = 1;
  localparam int OUT_MTMO   = 2;
  localparam int OUT_CTMO   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       vblnk_in;
  logic       enable;
  logic [3:0] speed_sel;
  logic       restart;
  logic       game_over;
  logic       busy;
  logic       overrun;
  logic       timeout_err;

  frame_tick_scheduler_if hs();

  frame_tick_scheduler #(.TIMEOUT(TMO), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .vblnk_in(vblnk_in), .enable(enable),
    .speed_sel(speed_sel), .restart(restart), .hs(hs),
    .game_over(game_over), .busy(busy), .overrun(overrun),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int outcome;
    int d1;
    int d2;
    int rise;
  } step_t;

  step_t exp_q[$];
  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;
  int    commit_cnt = 0;
  bit    mon_en = 1'b0;
  bit    stray_go = 1'b0;
  bit    stray_seen = 1'b0;

  // reference model state
  int m_cnt = 0;
  bit m_go = 1'b0;
  bit m_ovr = 1'b0;
  bit m_tmo = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (hs.commit) commit_cnt <= commit_cnt + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  // One video frame: blanking low for lo cycles, then high for hi cycles.
  task automatic frame(input int lo, input int hi, input bit busy_edge,
                       input bit overlap, input int outcome, input int d1, input int d2);
    int    eff;
    step_t s;
    vblnk_in = 1'b0;
    repeat (lo) cyc1();
    vblnk_in = 1'b1;
    eff = (speed_sel == 4'd0) ? 1 : int'(speed_sel);
    if (busy_edge) begin
      m_ovr = 1'b1;
    end else if (!m_go && enable) begin
      if (m_cnt >= eff - 1) begin
        m_cnt = 0;
        s.outcome = outcome; s.d1 = d1; s.d2 = d2; s.rise = cyc + 2;
        exp_q.push_back(s);
        if (outcome == OUT_OVER) m_go = 1'b1;
        if (outcome == OUT_MTMO || outcome == OUT_CTMO) m_tmo = 1'b1;
      end else begin
        m_cnt++;
      end
    end
    repeat (hi) cyc1();
    check("overrun at frame end", overrun, m_ovr);
    check("timeout_err at frame end", timeout_err, m_tmo);
    check("game_over at frame end", game_over, m_go);
    if (!overlap) check("busy at frame end", busy, 0);
  endtask

  task automatic do_restart();
    vblnk_in = 1'b0;
    cyc1();
    restart = 1'b1;
    cyc1();
    restart = 1'b0;
    cyc1();
    if (m_go) begin
      m_go = 1'b0; m_cnt = 0; m_ovr = 1'b0; m_tmo = 1'b0;
    end
    check("game_over after restart", game_over, m_go);
    check("busy after restart", busy, 0);
    check("overrun after restart", overrun, m_ovr);
    check("timeout_err after restart", timeout_err, m_tmo);
  endtask

  // Responder + checker for one step sequence starting at move_req.
  task automatic handle_step();
    step_t s;
    int    m;
    int    w;
    m = cyc;
    if (exp_q.size() == 0) begin
      check("unexpected move_req", 1, 0);
      w = 0;
      while (hs.move_req && w < TMO + 8) begin @(negedge clk); w++; end
      return;
    end
    s = exp_q.pop_front();
    check("move_req rise cycle", m, s.rise);
    check("check_req low in MOVE", hs.check_req, 0);
    if (s.outcome == OUT_MTMO) begin
      w = 0;
      while (hs.move_req && w < TMO + 8) begin @(negedge clk); w++; end
      check("move timeout length", w, TMO);
      check("timeout_err after move timeout", timeout_err, 1);
      check("check_req after move timeout", hs.check_req, 0);
      check("busy after move timeout", busy, 0);
      return;
    end
    for (int i = 0; i < s.d1; i++) begin
      hs.check_done = (i == 0 && s.d1 >= 2);
      hs.collision  = hs.check_done;
      @(negedge clk);
    end
    hs.check_done = 1'b0;
    hs.collision  = 1'b0;
    hs.move_done  = 1'b1;
    @(negedge clk);
    hs.move_done = 1'b0;
    check("check_req after move_done", hs.check_req, 1);
    check("move_req drop after move_done", hs.move_req, 0);
    if (s.outcome == OUT_CTMO) begin
      w = 0;
      while (hs.check_req && w < TMO + 8) begin @(negedge clk); w++; end
      check("check timeout length", w, TMO);
      check("timeout_err after check timeout", timeout_err, 1);
      check("commit after check timeout", hs.commit, 0);
      check("busy after check timeout", busy, 0);
      return;
    end
    for (int i = 0; i < s.d2; i++) begin
      hs.move_done = (i == 0 && s.d2 >= 2);
      @(negedge clk);
    end
    hs.move_done  = 1'b0;
    hs.check_done = 1'b1;
    hs.collision  = (s.outcome == OUT_OVER);
    @(negedge clk);
    hs.check_done = 1'b0;
    hs.collision  = 1'b0;
    check("check_req drop after check_done", hs.check_req, 0);
    if (s.outcome == OUT_OVER) begin
      check("game_over on collision", game_over, 1);
      check("commit on collision", hs.commit, 0);
      check("busy in GAMEOVER", busy, 0);
    end else begin
      check("commit pulse", hs.commit, 1);
      check("busy in COMMIT", busy, 1);
      @(negedge clk);
      check("commit single cycle", hs.commit, 0);
      check("busy after COMMIT", busy, 0);
    end
  endtask

  // Monitor/responder: sole driver of the datapath-side handshake inputs.
  initial begin
    hs.move_done  = 1'b0;
    hs.check_done = 1'b0;
    hs.collision  = 1'b0;
    forever begin
      @(negedge clk);
      if (stray_go != stray_seen) begin
        hs.move_done  = 1'b1;
        hs.check_done = 1'b1;
        hs.collision  = 1'b1;
        @(negedge clk);
        hs.move_done  = 1'b0;
        hs.check_done = 1'b0;
        hs.collision  = 1'b0;
        stray_seen = stray_go;
      end else if (mon_en && hs.move_req) begin
        handle_step();
      end
    end
  end

  initial begin
    int c0;
    int w;
    int bad;
    int r;
    int oc;
    rst = 1'b0; vblnk_in = 1'b0; enable = 1'b0; restart = 1'b0; speed_sel = 4'd0;
    repeat (3) cyc1();
    check("reset move_req", hs.move_req, 0);
    check("reset check_req", hs.check_req, 0);
    check("reset commit", hs.commit, 0);
    check("reset game_over", game_over, 0);
    check("reset busy", busy, 0);
    check("reset overrun", overrun, 0);
    check("reset timeout_err", timeout_err, 0);
    rst = 1'b1;
    mon_en = 1'b1;
    cyc1(); cyc1();

    // speed 3, six edges, done after 2 cycles, no collision
    enable = 1'b1; speed_sel = 4'd3; c0 = commit_cnt;
    for (int i = 0; i < 6; i++) frame(3, 30, 1'b0, 1'b0, OUT_COMMIT, 2, 2);
    check("commits over six edges at speed 3", commit_cnt - c0, 2);

    // speed 0 behaves as 1: a step every edge
    speed_sel = 4'd0; c0 = commit_cnt;
    for (int i = 0; i < 4; i++)
      frame(3, 30, 1'b0, 1'b0, OUT_COMMIT, $urandom_range(0, 4), $urandom_range(0, 4));
    check("commits at speed 0", commit_cnt - c0, 4);

    // collision, ignored edges in GAMEOVER, restart
    speed_sel = 4'd1;
    frame(3, 30, 1'b0, 1'b0, OUT_OVER, 1, 3);
    frame(3, 30, 1'b0, 1'b0, OUT_COMMIT, 0, 0);
    frame(3, 30, 1'b0, 1'b0, OUT_COMMIT, 0, 0);
    do_restart();

    // handshake timeouts, then normal steps
    frame(3, 30, 1'b0, 1'b0, OUT_MTMO, 0, 0);
    check("move_req low after timeout", hs.move_req, 0);
    frame(3, 30, 1'b0, 1'b0, OUT_COMMIT, 1, 1);
    frame(3, 30, 1'b0, 1'b0, OUT_CTMO, 2, 0);
    frame(3, 30, 1'b0, 1'b0, OUT_COMMIT, 0, 1);

    // long CHECK spans a vblank fall and the next edge
    c0 = commit_cnt;
    frame(2, 5, 1'b0, 1'b1, OUT_COMMIT, 0, 12);
    frame(2, 30, 1'b1, 1'b0, OUT_COMMIT, 0, 0);
    check("commit despite overrun", commit_cnt - c0, 1);
    frame(3, 30, 1'b0, 1'b0, OUT_COMMIT, 1, 1);

    // randomized frames
    for (int i = 0; i < 40; i++) begin
      speed_sel = 4'($urandom_range(0, 4));
      enable = ($urandom_range(0, 7) != 0);
      r = $urandom_range(0, 9);
      oc = (r < 7) ? OUT_COMMIT : (r == 7) ? OUT_OVER : (r == 8) ? OUT_MTMO : OUT_CTMO;
      frame($urandom_range(2, 6), $urandom_range(28, 34), 1'b0, 1'b0, oc,
            $urandom_range(0, 4), $urandom_range(0, 4));
      if (m_go || ($urandom_range(0, 9) == 0)) do_restart();
    end

    // end the game to clear sticky flags
    enable = 1'b1; speed_sel = 4'd1;
    frame(3, 30, 1'b0, 1'b0, OUT_OVER, 0, 0);
    do_restart();

    // reset during MOVE, stray dones after release, vblank high at release
    mon_en = 1'b0;
    frame(3, 0, 1'b0, 1'b1, OUT_COMMIT, 0, 0);
    w = 0;
    while (!hs.move_req && w < 10) begin cyc1(); w++; end
    check("move_req before reset", hs.move_req, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("move_req dropped by reset", hs.move_req, 0);
    check("busy dropped by reset", busy, 0);
    check("check_req under reset", hs.check_req, 0);
    check("commit under reset", hs.commit, 0);
    void'(exp_q.pop_front());
    cyc1(); cyc1();
    rst = 1'b1;
    m_cnt = 0; m_go = 1'b0; m_ovr = 1'b0; m_tmo = 1'b0;
    stray_go = ~stray_go;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      cyc1();
      if (hs.move_req || hs.check_req || hs.commit || busy || game_over) bad++;
    end
    check("no activity after reset release", bad, 0);
    mon_en = 1'b1;
    frame(3, 30, 1'b0, 1'b0, OUT_COMMIT, 1, 1);

    check("scoreboard drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run always reaches its summary.
  initial begin
    #2000000;
    $display("FAIL time limit: got timeout expected finish");
    $fatal(1, "time limit");
  end

endmodule
